// File: rtl/memory_arbiter_ctrl.sv
// Two-port arbiter and strobe sequencer for eight bit-sliced 1-bit memory chips.
// Optional write-verify read-back is enabled by defining MEM_ARBITER_CTRL_VERIFY_EN.
module memory_arbiter_ctrl #(
    parameter int STROBE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       a_req,
    input  logic       a_we,
    input  logic [5:0] a_addr,
    input  logic [7:0] a_wdata,
    input  logic       b_req,
    input  logic       b_we,
    input  logic [5:0] b_addr,
    input  logic [7:0] b_wdata,
    output logic       a_ack,
    output logic [7:0] a_rdata,
    output logic       b_ack,
    output logic [7:0] b_rdata,
    output logic [7:0] mem_address,
    inout  logic [7:0] mem_data,
    output logic       mem_chip_enable,
    output logic       mem_write_enable,
    output logic       mem_out_enable,
    output logic       busy,
    output logic       verify_err
);

    localparam logic [2:0] LAST_CNT = 3'(STROBE_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        VERIFY,
        DONE
    } state_t;

    state_t     state_reg, state_next;
    logic [2:0] cnt_reg, cnt_next;

    // last_b_reg doubles as the owner of the transaction in flight and as the
    // arbitration history; it resets to 1 so port A wins the first tie.
    logic       last_b_reg;
    logic       we_reg;
    logic [5:0] addr_reg;
    logic [7:0] wdata_reg;
    logic [7:0] cap_reg;
    logic [7:0] a_rdata_reg;
    logic [7:0] b_rdata_reg;

    logic       grant_fire;
    logic       grant_b_next;
    logic       last_cycle;
    logic       drive_data;

    assign last_cycle = (cnt_reg == LAST_CNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= 3'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        grant_fire   = 1'b0;
        grant_b_next = b_req && (!a_req || !last_b_reg);
        case (state_reg)
            IDLE: begin
                if (a_req || b_req) begin
                    grant_fire = 1'b1;
                    state_next = SETUP;
                    cnt_next   = 3'd0;
                end
            end
            SETUP: begin
                state_next = STROBE;
                cnt_next   = 3'd0;
            end
            STROBE: begin
                if (last_cycle) begin
                    state_next = HOLD;
                    cnt_next   = 3'd0;
                end else begin
                    cnt_next = cnt_reg + 3'd1;
                end
            end
            HOLD: begin
`ifdef MEM_ARBITER_CTRL_VERIFY_EN
                state_next = we_reg ? VERIFY : DONE;
`else
                state_next = DONE;
`endif
                cnt_next = 3'd0;
            end
            VERIFY: begin
                if (last_cycle) begin
                    state_next = DONE;
                    cnt_next   = 3'd0;
                end else begin
                    cnt_next = cnt_reg + 3'd1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_b_reg  <= 1'b1;
            we_reg      <= 1'b0;
            addr_reg    <= 6'd0;
            wdata_reg   <= 8'd0;
            cap_reg     <= 8'd0;
            a_rdata_reg <= 8'd0;
            b_rdata_reg <= 8'd0;
        end else begin
            if (grant_fire) begin
                last_b_reg <= grant_b_next;
                we_reg     <= grant_b_next ? b_we    : a_we;
                addr_reg   <= grant_b_next ? b_addr  : a_addr;
                wdata_reg  <= grant_b_next ? b_wdata : a_wdata;
            end
            if (state_reg == STROBE && !we_reg && last_cycle) begin
                cap_reg <= mem_data;
            end
            // Only the owning port's read register moves, so the other port keeps its byte.
            if (state_reg == HOLD && !we_reg) begin
                if (last_b_reg) begin
                    b_rdata_reg <= cap_reg;
                end else begin
                    a_rdata_reg <= cap_reg;
                end
            end
        end
    end

`ifdef MEM_ARBITER_CTRL_VERIFY_EN
    logic verr_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            verr_reg <= 1'b0;
        end else if (grant_fire) begin
            verr_reg <= 1'b0;
        end else if (state_reg == VERIFY && last_cycle) begin
            verr_reg <= (mem_data != wdata_reg);
        end
    end

    assign verify_err = (state_reg == DONE) && verr_reg;
`else
    assign verify_err = 1'b0;
`endif

    assign busy             = (state_reg != IDLE);
    assign mem_chip_enable  = (state_reg == SETUP) || (state_reg == STROBE) ||
                              (state_reg == HOLD)  || (state_reg == VERIFY);
    assign mem_write_enable = (state_reg == STROBE) && we_reg;
    assign mem_out_enable   = ((state_reg == STROBE) && !we_reg) || (state_reg == VERIFY);
    assign mem_address      = {2'b00, addr_reg};
    assign a_ack            = (state_reg == DONE) && !last_b_reg;
    assign b_ack            = (state_reg == DONE) && last_b_reg;
    assign a_rdata          = a_rdata_reg;
    assign b_rdata          = b_rdata_reg;

    // Write data is held on the bus from SETUP through HOLD so the chips see stable data around the strobe.
    assign drive_data = we_reg && ((state_reg == SETUP) || (state_reg == STROBE) || (state_reg == HOLD));

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_chip_bit
            assign mem_data[gi] = drive_data ? wdata_reg[gi] : 1'bz;
        end
    endgenerate

endmodule

// File: tb/tb_memory_arbiter_ctrl.sv
// Scoreboard bench for memory_arbiter_ctrl: randomized two-port traffic against
// a byte-array reference model plus a simple model of the eight memory chips.
module tb_memory_arbiter_ctrl;

    localparam int N = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
    logic [5:0] a_addr = '0, b_addr = '0;
    logic [7:0] a_wdata = '0, b_wdata = '0;
    logic       a_ack, b_ack;
    logic [7:0] a_rdata, b_rdata;
    logic [7:0] mem_address;
    wire  [7:0] mem_data;
    logic       mem_chip_enable, mem_write_enable, mem_out_enable, busy, verify_err;

    memory_arbiter_ctrl #(.STROBE_CYCLES(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .a_ack(a_ack), .a_rdata(a_rdata), .b_ack(b_ack), .b_rdata(b_rdata),
        .mem_address(mem_address), .mem_data(mem_data),
        .mem_chip_enable(mem_chip_enable), .mem_write_enable(mem_write_enable),
        .mem_out_enable(mem_out_enable), .busy(busy), .verify_err(verify_err)
    );

    always #5 clk = ~clk;

    // Physical memory: eight 64x1 chips seen together as one byte-wide array.
    logic [7:0] chip_mem [64] = '{default: 8'h00};
    always @(posedge clk) begin
        if (mem_chip_enable && mem_write_enable) chip_mem[mem_address[5:0]] <= mem_data;
    end
    assign mem_data = (mem_chip_enable && mem_out_enable) ? chip_mem[mem_address[5:0]] : 8'bz;

    typedef struct {
        bit         port;
        bit         we;
        logic [5:0] addr;
        logic [7:0] data;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] ref_mem [64] = '{default: 8'h00};
    bit         last_b = 1'b1;
    int         checks = 0;
    int         errors = 0;
    bit         timeout_hit = 1'b0;

    // ---------------- monitor / checker ----------------
    int         cyc = 0, start_cyc = 0, we_cnt = 0, oe_cnt = 0, wd = 0, txn_no = 0;
    bit         busy_q = 1'b0, addr_seen = 1'b0;
    logic [7:0] strobe_addr = '0;
    logic [7:0] sh_a = '0, sh_b = '0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at cycle %0d", name, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        int   lat_exp, we_exp, oe_exp;
        cyc++;
        if (!rst_n) begin
            chk("rst_a_ack", a_ack, 0);
            chk("rst_b_ack", b_ack, 0);
            chk("rst_ce", mem_chip_enable, 0);
            chk("rst_we", mem_write_enable, 0);
            chk("rst_oe", mem_out_enable, 0);
            chk("rst_busy", busy, 0);
            chk("rst_verify_err", verify_err, 0);
            chk("rst_mem_address", mem_address, 0);
            chk("rst_a_rdata", a_rdata, 0);
            chk("rst_b_rdata", b_rdata, 0);
            exp_q.delete();
            sh_a = '0; sh_b = '0; busy_q = 1'b0; wd = 0;
        end else begin
            if (busy && !busy_q) begin
                start_cyc = cyc; we_cnt = 0; oe_cnt = 0; addr_seen = 1'b0;
            end
            if (mem_write_enable || mem_out_enable) begin
                chk("enable_overlap", {31'd0, mem_write_enable && mem_out_enable}, 0);
                if (mem_write_enable) we_cnt++;
                if (mem_out_enable) oe_cnt++;
                if (!addr_seen) begin strobe_addr = mem_address; addr_seen = 1'b1; end
            end
            if (a_ack || b_ack) begin
                wd = 0;
                chk("dual_ack", {31'd0, a_ack && b_ack}, 0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_ack", {31'd0, b_ack}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    txn_no++;
`ifdef MEM_ARBITER_CTRL_VERIFY_EN
                    lat_exp = e.we ? 3 + 2 * N : 3 + N;
                    oe_exp  = N;
`else
                    lat_exp = 3 + N;
                    oe_exp  = e.we ? 0 : N;
`endif
                    we_exp = e.we ? N : 0;
                    if (!e.we) begin
                        if (e.port) sh_b = e.data; else sh_a = e.data;
                    end
                    chk("grant_port", {31'd0, b_ack}, {31'd0, e.port});
                    chk("latency", cyc - start_cyc + 1, lat_exp);
                    chk("we_cycles", we_cnt, we_exp);
                    chk("oe_cycles", oe_cnt, oe_exp);
                    chk("strobe_addr", strobe_addr, {2'b00, e.addr});
                    chk("addr_hi_zero", {30'd0, mem_address[7:6]}, 0);
                    chk("a_rdata", a_rdata, sh_a);
                    chk("b_rdata", b_rdata, sh_b);
                    chk("verify_err", verify_err, 0);
                    $display("txn %0d port=%s %s addr=%02h data=%02h lat=%0d",
                             txn_no, e.port ? "B" : "A", e.we ? "WR" : "RD", e.addr, e.data,
                             cyc - start_cyc + 1);
                end
            end else if (a_req || b_req) begin
                wd++;
                if (wd == 200) begin
                    chk("ack_timeout", wd, 0);
                    timeout_hit = 1'b1;
                end
            end
            busy_q = busy;
        end
    end

    // ---------------- driver / reference model ----------------
    task automatic push(input bit port, input bit we, input logic [5:0] addr, input logic [7:0] wdata);
        exp_t e;
        e.port = port; e.we = we; e.addr = addr;
        if (we) begin
            ref_mem[addr] = wdata;
            e.data = wdata;
        end else begin
            e.data = ref_mem[addr];
        end
        last_b = port;
        exp_q.push_back(e);
    endtask

    task automatic run_pair(input bit ea, input bit wa, input logic [5:0] aa, input logic [7:0] da,
                            input bit eb, input bit wb, input logic [5:0] ab, input logic [7:0] db);
        @(negedge clk);
        a_we = wa; a_addr = aa; a_wdata = da;
        b_we = wb; b_addr = ab; b_wdata = db;
        a_req = ea; b_req = eb;
        // A tie goes to whichever port was not served last.
        if (ea && eb) begin
            if (last_b) begin
                push(1'b0, wa, aa, da); push(1'b1, wb, ab, db);
            end else begin
                push(1'b1, wb, ab, db); push(1'b0, wa, aa, da);
            end
        end else if (ea) begin
            push(1'b0, wa, aa, da);
        end else if (eb) begin
            push(1'b1, wb, ab, db);
        end
        for (int i = 0; i < 300 && (a_req || b_req); i++) begin
            @(negedge clk);
            if (a_ack) a_req = 1'b0;
            if (b_ack) b_req = 1'b0;
            if (timeout_hit) begin a_req = 1'b0; b_req = 1'b0; end
        end
        a_req = 1'b0; b_req = 1'b0;
    endtask

    initial begin
        bit         ea, eb, wa, wb;
        int         mode;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Directed: write then cross-port read of the same location.
        run_pair(1, 1, 6'h2D, 8'hA5, 0, 0, 6'h00, 8'h00);
        run_pair(0, 0, 6'h00, 8'h00, 1, 0, 6'h2D, 8'h00);
        // Three simultaneous requests in a row.
        run_pair(1, 0, 6'h2D, 8'h00, 1, 1, 6'h11, 8'h5A);
        run_pair(1, 1, 6'h22, 8'hC3, 1, 0, 6'h11, 8'h00);
        run_pair(1, 0, 6'h22, 8'h00, 1, 0, 6'h2D, 8'h00);
        // Address and data extremes.
        run_pair(1, 1, 6'h00, 8'hFF, 1, 1, 6'h3F, 8'h00);
        run_pair(1, 0, 6'h00, 8'h00, 1, 0, 6'h3F, 8'h00);
        run_pair(1, 1, 6'h00, 8'h00, 1, 1, 6'h3F, 8'hFF);
        run_pair(1, 0, 6'h3F, 8'h00, 1, 0, 6'h00, 8'h00);

        // Randomized traffic.
        for (int n = 0; n < 40; n++) begin
            mode = $urandom_range(0, 2);
            ea = (mode != 1); eb = (mode != 0);
            wa = $urandom_range(0, 1) != 0; wb = $urandom_range(0, 1) != 0;
            run_pair(ea, wa, 6'($urandom_range(0, 63)), 8'($urandom_range(0, 255)),
                     eb, wb, 6'($urandom_range(0, 63)), 8'($urandom_range(0, 255)));
        end

        // Reset in the middle of a write strobe: no ack, and A owns the next tie.
        @(negedge clk);
        a_we = 1'b1; a_addr = 6'h15; a_wdata = 8'h77; a_req = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_write_enable) break;
        end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        a_req = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        last_b = 1'b1;
        run_pair(1, 1, 6'h15, 8'h3C, 1, 0, 6'h15, 8'h00);
        run_pair(1, 0, 6'h3F, 8'h00, 1, 0, 6'h00, 8'h00);

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/memory_arbiter_ctrl.md
MEMORY_ARBITER_CTRL -- requirements
Module: memory_arbiter_ctrl

Interface
REQ-001 Parameter: STROBE_CYCLES, default 2, width of the write/read enable strobe in clocks (legal 1-8).
REQ-002 clk  input  1  single system clock, all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 a_req / b_req  input  1 each  access request from port A / port B, level, held until ack.
REQ-005 a_we / b_we  input  1 each  1 = write, 0 = read.
REQ-006 a_addr / b_addr  input  6 each  byte address, row = bits[2:0], column = bits[5:3].
REQ-007 a_wdata / b_wdata  input  8 each  write byte.
REQ-008 a_ack / b_ack  output  1 each  one-cycle completion pulse.
REQ-009 a_rdata / b_rdata  output  8 each  read byte, valid while ack high, held until next read on that port.
REQ-010 mem_address  output  8  shared address to the eight bit-sliced memory chips, bits[7:6] always 0.
REQ-011 mem_data  inout  8  bit i connects to data_bit of chip i.
REQ-012 mem_chip_enable, mem_write_enable, mem_out_enable  output  1 each  common chip controls.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 verify_err  output  1  write-verify mismatch pulse (see Configuration).

Function
REQ-015 FSM states: IDLE, SETUP, STROBE, HOLD, VERIFY, DONE.
REQ-016 IDLE: all enables 0, mem_data high-Z; on any req, grant one port, latch its we/addr/wdata, go SETUP next cycle.
REQ-017 Arbitration: single req wins; both req -> port not granted last; after reset A has priority.
REQ-018 SETUP (1 cycle): mem_address = latched addr, mem_chip_enable=1, write/out enables 0; write op drives mem_data = wdata.
REQ-019 STROBE (STROBE_CYCLES cycles): write -> mem_write_enable=1; read -> mem_out_enable=1, mem_data captured on last STROBE cycle.
REQ-020 HOLD (1 cycle): mem_chip_enable=1, write/out enables 0, address and write data held stable.
REQ-021 HOLD -> VERIFY for writes when macro enabled, else -> DONE.
REQ-022 DONE (1 cycle): granted port ack=1, read data presented on its rdata; next state IDLE.
REQ-023 Latency: ack asserts 3+STROBE_CYCLES clocks after the granting edge (reads and non-verified writes).
REQ-024 mem_write_enable and mem_out_enable never high in the same cycle; mem_data driven only in SETUP/STROBE/HOLD of a write.
REQ-025 Request inputs ignored outside IDLE; req still high in the cycle after ack counts as a new request.
REQ-026 Ungranted port's ack, rdata unaffected by the other port's transaction.

Reset
REQ-027 rst_n low: state IDLE, all enables 0, mem_address 0, mem_data high-Z, acks 0, rdata 0, busy 0, verify_err 0, priority to A -- immediately, without clock.
REQ-028 Reset mid-transaction aborts it with no ack; memory content at the addressed location is undefined for an aborted write.

Configuration
REQ-029 Macro MEM_ARBITER_CTRL_VERIFY_EN defined: after each write HOLD, VERIFY runs STROBE_CYCLES cycles with mem_out_enable=1, compares captured byte to wdata; mismatch -> verify_err=1 during DONE; write ack latency becomes 3+2*STROBE_CYCLES.
REQ-030 Macro undefined: VERIFY unreachable, verify_err tied 0.

Verification
REQ-031 Reset, A writes 0xA5 to addr 0x2D, STROBE_CYCLES=2 -> mem_write_enable high exactly 2 cycles, mem_address 0x2D, a_ack at cycle 5 after grant.
REQ-032 B reads addr 0x2D after REQ-031 -> b_rdata = 0xA5 with b_ack, mem_out_enable high 2 cycles, mem_data never driven by controller.
REQ-033 a_req and b_req raised together three times back-to-back -> grant order A, B, A; no overlap of enables between transactions.
REQ-034 rst_n pulled low during STROBE of a write -> enables drop 0 same cycle, no ack, busy 0, next simultaneous request granted to A.
REQ-035 Writes of 0x00 and 0xFF to addresses 0x00 and 0x3F, read back -> exact values, mem_address[7:6] always 0.
REQ-036 With MEM_ARBITER_CTRL_VERIFY_EN, force chip 3 data_bit stuck-at-0, write 0x08 -> verify_err=1 with ack at cycle 7; without macro verify_err stays 0.
